huffman_decoder: RTL and testbench



---
 rtl/huffman_decoder.sv | 128 ++++++++++++
 tb/tb_huffman_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: loads an 8-entry code table, then decodes
// MSB-first code bits into 4-bit characters with end-of-message and error flags.
module huffman_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tab_valid,
    input  logic [3:0] tab_char,
    input  logic [2:0] tab_len,
    input  logic [6:0] tab_code,
    input  logic       in_valid,
    input  logic       in_code,
    output logic       out_valid,
    output logic [3:0] out_char,
    output logic       out_done,
    output logic       out_err
);

    localparam int CHAR_NUM = 8;
    localparam int MAX_LEN  = 7;
    localparam int MSG_LEN  = 5;

    typedef enum logic [1:0] {
        EMPTY,
        LOAD,
        READY,
        DECODE
    } state_t;

    state_t     state;
    logic [2:0] ld_idx;
    logic [3:0] t_char [CHAR_NUM];
    logic [2:0] t_len  [CHAR_NUM];
    logic [6:0] t_code [CHAR_NUM];
    logic [6:0] acc;
    logic [2:0] cnt;
    logic [2:0] ccnt;

    logic [6:0] nacc;
    logic [2:0] ncnt;
    logic [6:0] mask;
    logic       hit;
    logic [2:0] hit_idx;

    // Candidate accumulator and table match; the lowest matching index wins.
    always_comb begin
        nacc    = {acc[5:0], in_code};
        ncnt    = cnt + 3'd1;
        mask    = 7'((8'd1 << ncnt) - 8'd1);
        hit     = 1'b0;
        hit_idx = 3'd0;
        for (int k = CHAR_NUM - 1; k >= 0; k--) begin
            if (t_len[k] == ncnt && t_len[k] != 3'd0 &&
                ((t_code[k] ^ nacc) & mask) == 7'd0) begin
                hit     = 1'b1;
                hit_idx = 3'(k);
            end
        end
    end

    // Table load, bit accumulation and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            ld_idx    <= 3'd0;
            acc       <= 7'd0;
            cnt       <= 3'd0;
            ccnt      <= 3'd0;
            out_valid <= 1'b0;
            out_char  <= 4'd0;
            out_done  <= 1'b0;
            out_err   <= 1'b0;
            for (int k = 0; k < CHAR_NUM; k++) begin
                t_char[k] <= 4'd0;
                t_len[k]  <= 3'd0;
                t_code[k] <= 7'd0;
            end
        end else begin
            out_valid <= 1'b0;
            out_char  <= 4'd0;
            out_done  <= 1'b0;
            out_err   <= 1'b0;
            if (tab_valid) begin
                t_char[ld_idx] <= tab_char;
                t_len[ld_idx]  <= tab_len;
                t_code[ld_idx] <= tab_code;
                acc            <= 7'd0;
                cnt            <= 3'd0;
                ccnt           <= 3'd0;
                if (ld_idx == 3'(CHAR_NUM - 1)) begin
                    ld_idx <= 3'd0;
                    state  <= READY;
                end else begin
                    ld_idx <= ld_idx + 3'd1;
                    state  <= LOAD;
                end
            end else if (state == LOAD) begin
                // Load stopped short of a full table: nothing usable.
                ld_idx <= 3'd0;
                state  <= EMPTY;
            end else if ((state == READY || state == DECODE) && in_valid) begin
                if (hit) begin
                    out_valid <= 1'b1;
                    out_char  <= t_char[hit_idx];
                    acc       <= 7'd0;
                    cnt       <= 3'd0;
                    state     <= READY;
                    if (ccnt == 3'(MSG_LEN - 1)) begin
                        out_done <= 1'b1;
                        ccnt     <= 3'd0;
                    end else begin
                        ccnt <= ccnt + 3'd1;
                    end
                end else if (ncnt != 3'(MAX_LEN)) begin
                    acc   <= nacc;
                    cnt   <= ncnt;
                    state <= DECODE;
                end else begin
                    out_err <= 1'b1;
                    acc     <= 7'd0;
                    cnt     <= 3'd0;
                    ccnt    <= 3'd0;
                    state   <= READY;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard testbench for huffman_decoder: expected outputs are queued
// with their due cycle when the completing bit is driven.
module tb_huffman_decoder;

    logic       clk;
    logic       rst_n;
    logic       tab_valid;
    logic [3:0] tab_char;
    logic [2:0] tab_len;
    logic [6:0] tab_code;
    logic       in_valid;
    logic       in_code;
    logic       out_valid;
    logic [3:0] out_char;
    logic       out_done;
    logic       out_err;

    huffman_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tab_valid (tab_valid),
        .tab_char  (tab_char),
        .tab_len   (tab_len),
        .tab_code  (tab_code),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .out_valid (out_valid),
        .out_char  (out_char),
        .out_done  (out_done),
        .out_err   (out_err)
    );

    typedef struct {
        int         cyc;
        logic [3:0] ch;
        logic       done;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [3:0] m_char [8];
    logic [2:0] m_len  [8];
    logic [6:0] m_code [8];

    localparam logic [3:0] CH_A = 4'h1, CH_B = 4'h2, CH_C = 4'h3,
                           CH_E = 4'h4, CH_I = 4'h5, CH_L = 4'h6,
                           CH_O = 4'h7, CH_V = 4'h8;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid || out_err || out_done) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output cyc=%0d got v=%b ch=%h d=%b e=%b want none",
                             cyc, out_valid, out_char, out_done, out_err);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if ({out_valid, out_char, out_done, out_err} !==
                        {~e.err, e.err ? 4'h0 : e.ch, e.done, e.err} || cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL output cyc=%0d got v=%b ch=%h d=%b e=%b want cyc=%0d v=%b ch=%h d=%b e=%b",
                                 cyc, out_valid, out_char, out_done, out_err,
                                 e.cyc, ~e.err, e.ch, e.done, e.err);
                    end
                end
            end else begin
                if (out_char !== 4'h0) begin
                    checks++;
                    errors++;
                    $display("FAIL idle_char cyc=%0d got %h want 0", cyc, out_char);
                end
                if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_output cyc=%0d got none want ch=%h d=%b e=%b",
                             cyc, e.ch, e.done, e.err);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] ch, input logic done, input logic err);
        exp_t e;
        e.cyc  = cyc + 1;
        e.ch   = ch;
        e.done = done;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic set_table(input logic unused7);
        m_char = '{CH_A, CH_B, CH_C, CH_E, CH_I, CH_L, CH_O, CH_V};
        m_len  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7};
        m_code = '{7'b0, 7'b10, 7'b110, 7'b1110, 7'b11110,
                   7'b111110, 7'b1111110, 7'b1111111};
        if (unused7) m_len[7] = 3'd0;
    endtask

    task automatic load_table;
        for (int i = 0; i < 8; i++) begin
            tab_valid = 1'b1;
            tab_char  = m_char[i];
            tab_len   = m_len[i];
            tab_code  = m_code[i];
            tick();
        end
        tab_valid = 1'b0;
        tab_char  = 4'h0;
        tab_len   = 3'd0;
        tab_code  = 7'd0;
    endtask

    // Send the code of table entry idx; gap idle cycles follow each bit.
    task automatic send_sym(input int idx, input logic done, input int gap);
        for (int b = int'(m_len[idx]) - 1; b >= 0; b--) begin
            if (b == 0) push(m_char[idx], done, 1'b0);
            in_valid = 1'b1;
            in_code  = m_code[idx][b];
            tick();
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) tick();
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_code  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() > 0 && t < 20) begin
            tick();
            t++;
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({out_valid, out_char, out_done, out_err} !== 7'd0) begin
            errors++;
            $display("FAIL %s got v=%b ch=%h d=%b e=%b want all 0",
                     name, out_valid, out_char, out_done, out_err);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tab_valid = 1'b0;
        tab_char = 4'h0;
        tab_len = 3'd0;
        tab_code = 7'd0;
        in_valid = 1'b0;
        in_code = 1'b0;
        repeat (3) tick();
        check_zero("reset_outputs");
        rst_n = 1'b1;
        tick();
        check_zero("after_reset_outputs");
    endtask

    task automatic test_no_table;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_code  = i[0];
            tick();
            check_zero("no_table");
        end
        idle(2);
    endtask

    task automatic test_message;
        set_table(1'b0);
        load_table();
        send_sym(4, 1'b0, 0);
        send_sym(5, 1'b0, 0);
        send_sym(6, 1'b0, 0);
        send_sym(7, 1'b0, 0);
        send_sym(3, 1'b1, 0);
        idle(2);
        drain("message");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 5; i++) send_sym(0, i == 4, 0);
        idle(2);
        drain("len1");
    endtask

    task automatic test_undecodable;
        set_table(1'b1);
        load_table();
        for (int i = 0; i < 7; i++) begin
            if (i == 6) push(4'h0, 1'b0, 1'b1);
            in_valid = 1'b1;
            in_code  = 1'b1;
            tick();
        end
        send_sym(0, 1'b0, 0);
        idle(2);
        drain("undecodable");
    endtask

    task automatic test_gap;
        send_sym(2, 1'b0, 3);
        idle(2);
        drain("gap");
    endtask

    task automatic test_abort;
        set_table(1'b0);
        for (int b = 5; b > 2; b--) begin
            in_valid = 1'b1;
            in_code  = m_code[5][b];
            tick();
        end
        in_valid = 1'b0;
        load_table();
        send_sym(5, 1'b0, 0);
        send_sym(1, 1'b0, 0);
        idle(2);
        drain("abort");
    endtask

    task automatic test_reset_mid;
        for (int b = 5; b > 2; b--) begin
            in_valid = 1'b1;
            in_code  = m_code[5][b];
            tick();
        end
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_code  = 1'b0;
            tick();
            check_zero("after_reset_empty");
        end
        idle(2);
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_no_table();
        test_message();
        test_back_to_back();
        test_undecodable();
        test_gap();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
